data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 103 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering CPU load/store requests after a fixed
// wait, with a one-cycle ready pulse and an error flag for rejected accesses.
module data_mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr_mem,
   input  logic [31:0] write_mem,
   output logic [31:0] read_mem,
   output logic        mem_ready,
   output logic        mem_error
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_rd;
   logic        r_wr;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_req;
   logic          w_cur_rd;
   logic          w_cur_wr;
   logic          w_cur_err;
   logic          w_enter_resp;
   logic [31:0]   w_cur_addr;
   logic [31:0]   w_cur_wdata;
   logic [AW-1:0] w_idx;

   // With zero wait cycles the commit edge is the accept edge, so the
   // transaction is taken straight from the inputs while still in IDLE.
   always_comb begin
      w_req        = MemRead | MemWrite;
      w_cur_addr   = (r_state == IDLE) ? addr_mem  : r_addr;
      w_cur_wdata  = (r_state == IDLE) ? write_mem : r_wdata;
      w_cur_rd     = (r_state == IDLE) ? MemRead   : r_rd;
      w_cur_wr     = (r_state == IDLE) ? MemWrite  : r_wr;
      w_idx        = w_cur_addr[AW+1:2];
      w_cur_err    = (w_cur_addr[1:0] != 2'b00)
                   | (w_cur_addr[31:AW+2] != '0)
                   | (w_cur_rd & w_cur_wr);
      w_enter_resp = ((r_state == IDLE) && w_req && (WAIT_CYCLES == 0))
                   | ((r_state == WAIT) && (r_cnt == 4'd1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_err     <= 1'b0;
         mem_ready <= 1'b0;
         mem_error <= 1'b0;
      end else begin
         mem_ready <= (r_state == RESP);
         mem_error <= (r_state == RESP) & r_err;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr  <= addr_mem;
                  r_wdata <= write_mem;
                  r_rd    <= MemRead;
                  r_wr    <= MemWrite;
                  r_err   <= w_cur_err;
                  r_cnt   <= WAIT_INIT;
                  r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= RESP;
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
         read_mem <= '0;
      end else if (w_enter_resp && !w_cur_err) begin
         if (w_cur_wr)      r_mem[w_idx] <= w_cur_wdata;
         else if (w_cur_rd) read_mem     <= r_mem[w_idx];
      end
   end

endmodule
